// File: rtl/maxnet_plu_seq.sv
// Sequencer for the Maxnet PLU datapath: loads operands, walks the result stages,
// and repeats with feedback until convergence or the iteration limit.
module maxnet_plu_seq #(
  parameter int STAGES   = 3,
  parameter int MAX_ITER = 8,
  parameter int ITER_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              converged,
  output logic              a_we,
  output logic              w_we,
  output logic              sel_fb,
  output logic [STAGES-1:0] r_we,
  output logic              busy,
  output logic              done,
  output logic [ITER_W-1:0] iter_cnt,
  output logic              timeout
);

  localparam int SIDX_W = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam logic [SIDX_W-1:0] LAST_SIDX = SIDX_W'(STAGES - 1);
  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(MAX_ITER - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STAGE,
    CHECK,
    DONE
  } state_t;

  state_t            state;
  logic [SIDX_W-1:0] sidx;

  // Outputs are registered: each transition loads the strobes of the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sidx     <= '0;
      iter_cnt <= '0;
      timeout  <= 1'b0;
      a_we     <= 1'b0;
      w_we     <= 1'b0;
      sel_fb   <= 1'b0;
      r_we     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      a_we   <= 1'b0;
      w_we   <= 1'b0;
      sel_fb <= 1'b0;
      r_we   <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= LOAD;
            iter_cnt <= '0;
            timeout  <= 1'b0;
            busy     <= 1'b1;
            a_we     <= 1'b1;
            w_we     <= 1'b1;
          end
        end
        LOAD: begin
          state <= STAGE;
          sidx  <= '0;
          busy  <= 1'b1;
          r_we  <= STAGES'(1);
        end
        STAGE: begin
          busy <= 1'b1;
          if (sidx == LAST_SIDX) begin
            state <= CHECK;
            sidx  <= '0;
          end else begin
            sidx <= sidx + 1'b1;
            r_we <= STAGES'(1) << (sidx + 1'b1);
          end
        end
        CHECK: begin
          // Convergence takes priority over the iteration limit.
          if (converged) begin
            state   <= DONE;
            timeout <= 1'b0;
            done    <= 1'b1;
          end else if (iter_cnt == LAST_ITER) begin
            state   <= DONE;
            timeout <= 1'b1;
            done    <= 1'b1;
          end else begin
            state    <= LOAD;
            iter_cnt <= iter_cnt + 1'b1;
            busy     <= 1'b1;
            a_we     <= 1'b1;
            sel_fb   <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_maxnet_plu_seq.sv
// Directed bench for maxnet_plu_seq with STAGES=3, MAX_ITER=4.
module tb_maxnet_plu_seq;

  logic       clk;
  logic       rst;
  logic       start;
  logic       converged;
  logic       a_we;
  logic       w_we;
  logic       sel_fb;
  logic [2:0] r_we;
  logic       busy;
  logic       done;
  logic [1:0] iter_cnt;
  logic       timeout;
  logic [7:0] outs;

  int totalChecks = 0;
  int failCount   = 0;

  maxnet_plu_seq #(
    .STAGES  (3),
    .MAX_ITER(4),
    .ITER_W  (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .converged(converged),
    .a_we     (a_we),
    .w_we     (w_we),
    .sel_fb   (sel_fb),
    .r_we     (r_we),
    .busy     (busy),
    .done     (done),
    .iter_cnt (iter_cnt),
    .timeout  (timeout)
  );

  assign outs = {a_we, w_we, sel_fb, r_we, busy, done};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", tag, observed, expected);
    end
  endtask

  // Inputs change 1 ns after an edge; outputs seen then belong to the next cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hand-derived strobe pattern {a_we,w_we,sel_fb,r_we,busy,done} for cycle c of an n-iteration run.
  function automatic logic [7:0] expVec(input int c, input int n);
    int ph;
    int k;
    if (c == n * 5 + 1) return 8'b0000_0001;
    if (c < 1 || c > n * 5 + 1) return 8'b0000_0000;
    ph = (c - 1) % 5;
    k  = (c - 1) / 5;
    case (ph)
      0:       return (k == 0) ? 8'b1100_0010 : 8'b1010_0010;
      1:       return 8'b0000_0110;
      2:       return 8'b0000_1010;
      3:       return 8'b0001_0010;
      default: return 8'b0000_0010;
    endcase
  endfunction

  task automatic applyStimulus(input string tag, input int n, input int convAt,
                               input int expIter, input logic expTimeout, input logic holdStart);
    start = 1'b1;
    tick();
    if (!holdStart) start = 1'b0;
    for (int c = 1; c <= n * 5 + 2; c++) begin
      converged = (c == convAt);
      checkOutput($sformatf("%s outs c%0d", tag, c), 32'(outs), 32'(expVec(c, n)));
      if ((c - 1) % 5 == 0 && c <= n * 5)
        checkOutput($sformatf("%s iter c%0d", tag, c), 32'(iter_cnt), 32'((c - 1) / 5));
      if (c == 1)
        checkOutput($sformatf("%s timeout c1", tag), 32'(timeout), 32'd0);
      if (c == n * 5 + 1) begin
        checkOutput($sformatf("%s done iter", tag), 32'(iter_cnt), 32'(expIter));
        checkOutput($sformatf("%s done timeout", tag), 32'(timeout), 32'(expTimeout));
      end
      if (c == n * 5 + 2) begin
        checkOutput($sformatf("%s hold iter", tag), 32'(iter_cnt), 32'(expIter));
        checkOutput($sformatf("%s hold timeout", tag), 32'(timeout), 32'(expTimeout));
      end
      tick();
    end
    converged = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b1;
    converged = 1'b0;

    // Reset held two cycles with start asserted.
    tick();
    tick();
    checkOutput("reset outs", 32'(outs), 32'd0);
    checkOutput("reset iter", 32'(iter_cnt), 32'd0);
    checkOutput("reset timeout", 32'(timeout), 32'd0);
    start = 1'b0;
    rst   = 1'b0;
    tick();
    checkOutput("post-reset no load", 32'(outs), 32'd0);
    tick();

    applyStimulus("single", 1, 5, 0, 1'b0, 1'b0);
    applyStimulus("three", 3, 15, 2, 1'b0, 1'b0);
    applyStimulus("limit", 4, 0, 3, 1'b1, 1'b0);
    applyStimulus("limitconv", 4, 20, 3, 1'b0, 1'b0);

    // Start held high: the second run must only begin after the DONE/IDLE pair.
    applyStimulus("held", 1, 5, 0, 1'b0, 1'b1);
    checkOutput("held 2nd load", 32'(outs), 32'(8'b1100_0010));
    checkOutput("held 2nd iter", 32'(iter_cnt), 32'd0);
    start = 1'b0;
    tick();
    checkOutput("abort stage0", 32'(outs), 32'(8'b0000_0110));
    tick();
    checkOutput("abort stage1", 32'(outs), 32'(8'b0000_1010));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("abort outs", 32'(outs), 32'd0);
    checkOutput("abort iter", 32'(iter_cnt), 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      checkOutput($sformatf("abort quiet %0d", i), 32'(outs), 32'd0);
    end

    applyStimulus("restart", 1, 5, 0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", totalChecks, failCount);
    $finish;
  end

endmodule
